// File: rtl/irq_controller.sv
// Interrupt controller: captures rising edges of the source lines into a pending register,
// masks them, and serves the highest-priority source through a req/ack/done handshake.
module irq_controller #(
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_in,
  output logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] pending,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] src_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] active;
  logic [ID_W-1:0]  winner;
  logic             ack_take;
  logic             load_id;

  assign rise     = src & ~src_d;
  assign active   = pending & mask;
  assign ack_take = (state == REQ) && irq_ack;
  assign clr      = ack_take ? (WIDTH'(1) << irq_id) : '0;

  // Ascending scan so the highest set index is the last assignment and wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (active[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_next = state;
    load_id    = 1'b0;
    case (state)
      IDLE: begin
        if (|active) begin
          state_next = REQ;
          load_id    = 1'b1;
        end
      end
      REQ:     if (irq_ack)  state_next = SERVICE;
      SERVICE: if (irq_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // src_d resets to all ones so a line already high at reset release is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_d   <= '1;
      pending <= '0;
      mask    <= '0;
      irq_id  <= '0;
    end else begin
      src_d   <= src;
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_in;
      if (load_id) irq_id <= winner;
    end
  end

  assign irq  = (state == REQ);
  assign busy = (state == SERVICE);

endmodule
